// File: rtl/transaction_timer_ctrl.sv
// Measurement sequencer for one transaction timer: arms it, gathers latency samples,
// keeps count/min/max/sum and recovers a hung timer with a one-cycle timer reset.
module transaction_timer_ctrl #(
  parameter int REG_SIZE = 32,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic                      i_cancel,
  input  logic [REG_SIZE-1:0]       i_start_address,
  input  logic [REG_SIZE-1:0]       i_stop_address,
  input  logic [CNT_W-1:0]          i_num_samples,
  input  logic [REG_SIZE-1:0]       i_timeout,
  output logic                      o_tmr_enable,
  output logic                      o_tmr_rst_n,
  output logic [REG_SIZE-1:0]       o_tmr_start_address,
  output logic [REG_SIZE-1:0]       o_tmr_stop_address,
  input  logic                      i_tmr_valid,
  input  logic [REG_SIZE-1:0]       i_tmr_time,
  input  logic                      i_tmr_busy,
  input  logic                      i_tmr_waiting,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_aborted,
  output logic [CNT_W-1:0]          o_samples,
  output logic [CNT_W-1:0]          o_timeouts,
  output logic [REG_SIZE-1:0]       o_min,
  output logic [REG_SIZE-1:0]       o_max,
  output logic [REG_SIZE+CNT_W-1:0] o_sum
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    RECOVER,
    DRAIN,
    DONE
  } state_t;

  state_t              state;
  logic                valid_q;
  logic [CNT_W-1:0]    attempts;
  logic [CNT_W-1:0]    num_q;
  logic [REG_SIZE-1:0] timeout_q;
  logic [REG_SIZE-1:0] tcnt;
  logic                valid_edge;
  logic                timeout_hit;
  logic                last_attempt;

  assign valid_edge   = i_tmr_valid & ~valid_q;
  assign timeout_hit  = (timeout_q != '0) && (tcnt == timeout_q);
  assign last_attempt = ((attempts + CNT_W'(1)) == num_q);

  assign o_tmr_enable = (state == RUN);
  assign o_tmr_rst_n  = (state != RECOVER);
  assign o_busy       = (state != IDLE);

  // Per-sample watchdog: only counts while the timer is busy measuring, not while it waits for AW
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tcnt    <= '0;
    end else begin
      valid_q <= i_tmr_valid;
      if (state != RUN || i_tmr_waiting || valid_edge)
        tcnt <= '0;
      else if (i_tmr_busy)
        tcnt <= tcnt + REG_SIZE'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      o_done              <= 1'b0;
      o_aborted           <= 1'b0;
      o_samples           <= '0;
      o_timeouts          <= '0;
      o_min               <= '1;
      o_max               <= '0;
      o_sum               <= '0;
      attempts            <= '0;
      num_q               <= '0;
      timeout_q           <= '0;
      o_tmr_start_address <= '0;
      o_tmr_stop_address  <= '0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            o_tmr_start_address <= i_start_address;
            o_tmr_stop_address  <= i_stop_address;
            num_q               <= i_num_samples;
            timeout_q           <= i_timeout;
            o_samples           <= '0;
            o_timeouts          <= '0;
            o_min               <= '1;
            o_max               <= '0;
            o_sum               <= '0;
            attempts            <= '0;
            o_aborted           <= 1'b0;
            state               <= (i_num_samples == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // A completed sample always wins over a coincident timeout; a coincident cancel still aborts
          if (valid_edge) begin
            o_samples <= o_samples + CNT_W'(1);
            attempts  <= attempts + CNT_W'(1);
            o_sum     <= o_sum + {{CNT_W{1'b0}}, i_tmr_time};
            if (i_tmr_time < o_min) o_min <= i_tmr_time;
            if (i_tmr_time > o_max) o_max <= i_tmr_time;
            if (i_cancel) o_aborted <= 1'b1;
            if (last_attempt)  state <= DRAIN;
            else if (i_cancel) state <= RECOVER;
          end else if (i_cancel) begin
            o_aborted <= 1'b1;
            state     <= RECOVER;
          end else if (timeout_hit) begin
            o_timeouts <= o_timeouts + CNT_W'(1);
            attempts   <= attempts + CNT_W'(1);
            state      <= RECOVER;
          end
        end
        RECOVER: begin
          state <= (o_aborted || attempts == num_q) ? DONE : RUN;
        end
        DRAIN: begin
          if (!i_tmr_busy) state <= DONE;
        end
        DONE: begin
          o_done <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_transaction_timer_ctrl.sv
// Bench for transaction_timer_ctrl: a stub timer plays samples and hangs, and a queue-based
// model of the collected latencies predicts the statistics at the end of each run.
module tb_transaction_timer_ctrl;
  localparam int REG_SIZE = 32;
  localparam int CNT_W    = 16;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      start, cancel;
  logic [REG_SIZE-1:0]       start_address, stop_address, timeout;
  logic [CNT_W-1:0]          num_samples;
  logic                      tmr_enable, tmr_rst_n;
  logic [REG_SIZE-1:0]       tmr_start_address, tmr_stop_address;
  logic                      tmr_valid, tmr_busy, tmr_waiting;
  logic [REG_SIZE-1:0]       tmr_time;
  logic                      busy, done, aborted;
  logic [CNT_W-1:0]          samples, timeouts;
  logic [REG_SIZE-1:0]       min_t, max_t;
  logic [REG_SIZE+CNT_W-1:0] sum_t;

  int checks = 0;
  int errors = 0;
  int unsigned exp_times[$];
  int exp_hangs;

  always #5 clk = ~clk;

  transaction_timer_ctrl #(.REG_SIZE(REG_SIZE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_cancel(cancel),
    .i_start_address(start_address), .i_stop_address(stop_address),
    .i_num_samples(num_samples), .i_timeout(timeout),
    .o_tmr_enable(tmr_enable), .o_tmr_rst_n(tmr_rst_n),
    .o_tmr_start_address(tmr_start_address), .o_tmr_stop_address(tmr_stop_address),
    .i_tmr_valid(tmr_valid), .i_tmr_time(tmr_time), .i_tmr_busy(tmr_busy),
    .i_tmr_waiting(tmr_waiting), .o_busy(busy), .o_done(done), .o_aborted(aborted),
    .o_samples(samples), .o_timeouts(timeouts), .o_min(min_t), .o_max(max_t), .o_sum(sum_t)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Starts a run, then scrambles the config inputs to show they were latched
  task automatic applyStimulus(input logic [CNT_W-1:0] num, input logic [REG_SIZE-1:0] to);
    logic [REG_SIZE-1:0] sa, sp;
    sa = $urandom;
    sp = $urandom;
    start_address = sa; stop_address = sp; num_samples = num; timeout = to; start = 1'b1;
    tick();
    start = 1'b0;
    start_address = ~sa; stop_address = ~sp; num_samples = num + 16'd3; timeout = to + 32'd7;
    checkOutput("start_addr_latched", 64'(tmr_start_address), 64'(sa));
    checkOutput("stop_addr_latched", 64'(tmr_stop_address), 64'(sp));
    exp_times.delete();
    exp_hangs = 0;
  endtask

  task automatic wait_enable();
    int n = 0;
    while (!tmr_enable && n < 100) begin tick(); n++; end
    checkOutput("enable_armed", 64'(tmr_enable), 64'd1);
  endtask

  task automatic do_sample(input int d, input logic [REG_SIZE-1:0] t);
    wait_enable();
    tmr_waiting = 1'b1;
    repeat (2) tick();
    tmr_waiting = 1'b0; tmr_busy = 1'b1;
    repeat (d) tick();
    tmr_busy = 1'b0; tmr_valid = 1'b1; tmr_time = t;
    tick();
    tmr_valid = 1'b0; tmr_waiting = 1'b1;
    exp_times.push_back(t);
  endtask

  // Timer goes busy and never sees its stop read; expect a timeout after 'to' busy cycles
  task automatic do_hang(input int to);
    int n = 0;
    wait_enable();
    tmr_waiting = 1'b1;
    tick();
    tmr_waiting = 1'b0; tmr_busy = 1'b1;
    while (tmr_rst_n && n < to + 20) begin tick(); n++; end
    checkOutput("timeout_latency", 64'(n), 64'(to + 1));
    checkOutput("tmr_reset_low", 64'(tmr_rst_n), 64'd0);
    checkOutput("enable_off_recover", 64'(tmr_enable), 64'd0);
    tmr_busy = 1'b0; tmr_waiting = 1'b1;
    tick();
    checkOutput("tmr_reset_one_cycle", 64'(tmr_rst_n), 64'd1);
    exp_hangs++;
  endtask

  task automatic finish_run(input string tag, input logic exp_aborted);
    int n = 0;
    logic [REG_SIZE-1:0]       mn = '1;
    logic [REG_SIZE-1:0]       mx = '0;
    logic [REG_SIZE+CNT_W-1:0] sm = '0;
    while (!done && n < 200) begin tick(); n++; end
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    foreach (exp_times[i]) begin
      if (exp_times[i] < mn) mn = exp_times[i];
      if (exp_times[i] > mx) mx = exp_times[i];
      sm += 48'(exp_times[i]);
    end
    checkOutput({tag, "_samples"}, 64'(samples), 64'(exp_times.size()));
    checkOutput({tag, "_timeouts"}, 64'(timeouts), 64'(exp_hangs));
    checkOutput({tag, "_min"}, 64'(min_t), 64'(mn));
    checkOutput({tag, "_max"}, 64'(max_t), 64'(mx));
    checkOutput({tag, "_sum"}, 64'(sum_t), 64'(sm));
    checkOutput({tag, "_aborted"}, 64'(aborted), 64'(exp_aborted));
    checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
    tick();
    checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_enable"}, 64'(tmr_enable), 64'd0);
    checkOutput({tag, "_tmr_rst_n"}, 64'(tmr_rst_n), 64'd1);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_aborted"}, 64'(aborted), 64'd0);
    checkOutput({tag, "_samples"}, 64'(samples), 64'd0);
    checkOutput({tag, "_timeouts"}, 64'(timeouts), 64'd0);
    checkOutput({tag, "_min"}, 64'(min_t), 64'hFFFF_FFFF);
    checkOutput({tag, "_max"}, 64'(max_t), 64'd0);
    checkOutput({tag, "_sum"}, 64'(sum_t), 64'd0);
    checkOutput({tag, "_start_addr"}, 64'(tmr_start_address), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0;
    start_address = '0; stop_address = '0; num_samples = '0; timeout = '0;
    tmr_valid = 1'b0; tmr_busy = 1'b0; tmr_waiting = 1'b1; tmr_time = '0;
    repeat (3) tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();

    $display("[TB] three samples, no timeout, start pulse mid-run");
    applyStimulus(16'd3, 32'd0);
    do_sample(10, 32'd10);
    num_samples = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    do_sample(20, 32'd20);
    do_sample(30, 32'd30);
    finish_run("three", 1'b0);

    $display("[TB] two hung attempts");
    applyStimulus(16'd2, 32'd50);
    do_hang(50);
    do_hang(50);
    finish_run("hang", 1'b0);

    $display("[TB] cancel after first sample");
    applyStimulus(16'd4, 32'd0);
    do_sample(5, 32'h1234);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checkOutput("cancel_tmr_reset_low", 64'(tmr_rst_n), 64'd0);
    tick();
    checkOutput("cancel_tmr_reset_high", 64'(tmr_rst_n), 64'd1);
    finish_run("cancel", 1'b1);

    $display("[TB] zero-sample run");
    applyStimulus(16'd0, 32'd0);
    checkOutput("zero_done_early", 64'(done), 64'd0);
    tick();
    finish_run("zero", 1'b0);

    $display("[TB] sample and timeout in the same cycle");
    applyStimulus(16'd1, 32'd12);
    do_sample(12, 32'h0000_0777);
    finish_run("tie_last", 1'b0);
    applyStimulus(16'd2, 32'd12);
    do_sample(12, 32'h0000_0500);
    do_sample(4, 32'h0000_0300);
    finish_run("tie_mid", 1'b0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 6; r++) begin
      int num;
      int to;
      num = int'($urandom_range(1, 5));
      to  = int'($urandom_range(16, 40));
      applyStimulus(CNT_W'(num), REG_SIZE'(to));
      for (int a = 0; a < num; a++) begin
        if ($urandom_range(0, 2) == 0) do_hang(to);
        else do_sample(int'($urandom_range(1, to - 1)), $urandom);
      end
      finish_run($sformatf("rand%0d", r), 1'b0);
    end

    $display("[TB] reset in the middle of a run");
    applyStimulus(16'd3, 32'd0);
    do_sample(6, 32'd99);
    rst_n = 1'b0;
    tick();
    check_reset_values("midreset");
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
